// File: rtl/doublebuffer_sched.sv
// Ping-pong CoRAM sequencer: pulls work tokens from the control channel, flips the
// buffer per block, launches the kernel and returns each result over the channel.
module doublebuffer_sched #(
    parameter int W_D   = 32,
    parameter int W_A   = 14,
    parameter int W_CNT = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [W_D-1:0]   comm_q,
    input  logic             comm_empty,
    output logic             comm_deq,
    output logic [W_D-1:0]   comm_d,
    input  logic             comm_full,
    output logic             comm_enq,
    output logic             buf_sel,
    output logic             run_start,
    output logic [W_A:0]     run_len,
    input  logic             run_done,
    input  logic [W_D-1:0]   run_result,
    output logic             busy,
    output logic             len_err,
    output logic [W_CNT-1:0] block_count
);
    typedef enum logic [2:0] {S_IDLE, S_DECODE, S_RUN, S_REPORT, S_FINISH} state_t;

    localparam logic [W_D-1:0] MAX_LEN = W_D'(1) << W_A;

    state_t           r_state, w_state;
    logic [W_D-1:0]   r_tok, w_tok, r_pend, w_pend, r_res, w_res, r_comm_d, w_comm_d;
    logic             r_pend_v, w_pend_v, r_buf_sel, w_buf_sel;
    logic             r_run_start, w_run_start, r_comm_deq, w_comm_deq, r_comm_enq, w_comm_enq;
    logic             r_busy, w_busy, r_len_err, w_len_err;
    logic [W_A:0]     r_run_len, w_run_len;
    logic [W_CNT-1:0] r_cnt, w_cnt;
    logic             w_over, w_pf_ok;
    logic [W_A:0]     w_clip;

    // Oversized tokens saturate at the largest block the memories can hold.
    assign w_over  = (r_tok > MAX_LEN);
    assign w_clip  = w_over ? (W_A+1)'(MAX_LEN) : r_tok[W_A:0];
    // A pop issued last cycle has not yet advanced the channel head.
    assign w_pf_ok = !r_pend_v && !comm_empty && !r_comm_deq;

    always_comb begin
        w_state     = r_state;
        w_tok       = r_tok;
        w_pend      = r_pend;
        w_pend_v    = r_pend_v;
        w_res       = r_res;
        w_comm_d    = r_comm_d;
        w_buf_sel   = r_buf_sel;
        w_run_len   = r_run_len;
        w_busy      = r_busy;
        w_len_err   = r_len_err;
        w_cnt       = r_cnt;
        w_run_start = 1'b0;
        w_comm_deq  = 1'b0;
        w_comm_enq  = 1'b0;
        if ((r_state == S_RUN || r_state == S_REPORT) && w_pf_ok) begin
            w_comm_deq = 1'b1;
            w_pend     = comm_q;
            w_pend_v   = 1'b1;
        end
        case (r_state)
            S_IDLE: begin
                if (r_pend_v) begin
                    w_tok    = r_pend;
                    w_pend_v = 1'b0;
                    w_state  = S_DECODE;
                end else if (!comm_empty) begin
                    w_comm_deq = 1'b1;
                    w_tok      = comm_q;
                    w_state    = S_DECODE;
                end
            end
            S_DECODE: begin
                if (r_tok == '0) begin
                    w_state = S_FINISH;
                end else begin
                    w_buf_sel   = ~r_buf_sel;
                    w_run_len   = w_clip;
                    w_len_err   = r_len_err | w_over;
                    w_run_start = 1'b1;
                    w_busy      = 1'b1;
                    w_state     = S_RUN;
                end
            end
            S_RUN: begin
                // The kernel cannot finish in the same cycle it is started.
                if (run_done && !r_run_start) begin
                    w_res   = run_result;
                    w_cnt   = r_cnt + W_CNT'(1);
                    w_state = S_REPORT;
                end
            end
            S_REPORT: begin
                if (!comm_full) begin
                    w_comm_d   = r_res;
                    w_comm_enq = 1'b1;
                    w_busy     = 1'b0;
                    w_state    = S_IDLE;
                end
            end
            S_FINISH: begin
                if (!comm_full) begin
                    w_comm_d   = W_D'(r_cnt);
                    w_comm_enq = 1'b1;
                    w_cnt      = '0;
                    w_state    = S_IDLE;
                end
            end
            default: w_state = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state     <= S_IDLE;
            r_tok       <= '0;
            r_pend      <= '0;
            r_pend_v    <= 1'b0;
            r_res       <= '0;
            r_comm_d    <= '0;
            r_buf_sel   <= 1'b1;
            r_run_len   <= '0;
            r_busy      <= 1'b0;
            r_len_err   <= 1'b0;
            r_cnt       <= '0;
            r_run_start <= 1'b0;
            r_comm_deq  <= 1'b0;
            r_comm_enq  <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_tok       <= w_tok;
            r_pend      <= w_pend;
            r_pend_v    <= w_pend_v;
            r_res       <= w_res;
            r_comm_d    <= w_comm_d;
            r_buf_sel   <= w_buf_sel;
            r_run_len   <= w_run_len;
            r_busy      <= w_busy;
            r_len_err   <= w_len_err;
            r_cnt       <= w_cnt;
            r_run_start <= w_run_start;
            r_comm_deq  <= w_comm_deq;
            r_comm_enq  <= w_comm_enq;
        end
    end

    assign comm_deq    = r_comm_deq;
    assign comm_d      = r_comm_d;
    assign comm_enq    = r_comm_enq;
    assign buf_sel     = r_buf_sel;
    assign run_start   = r_run_start;
    assign run_len     = r_run_len;
    assign busy        = r_busy;
    assign len_err     = r_len_err;
    assign block_count = r_cnt;
endmodule

// File: tb/tb_doublebuffer_sched.sv
// Directed bench for doublebuffer_sched: a FWFT channel model feeds tokens, a
// vector table covers block lengths and clipping, hand sequences cover timing corners.
module tb_doublebuffer_sched;
    localparam int W_D = 32, W_A = 14, W_CNT = 16;

    logic             CLK = 1'b0, RST = 1'b1;
    logic [W_D-1:0]   comm_q, comm_d, run_result;
    logic             comm_empty, comm_deq, comm_full, comm_enq;
    logic             buf_sel, run_start, run_done, busy, len_err;
    logic [W_A:0]     run_len;
    logic [W_CNT-1:0] block_count;

    doublebuffer_sched #(.W_D(W_D), .W_A(W_A), .W_CNT(W_CNT)) dut (
        .CLK(CLK), .RST(RST), .comm_q(comm_q), .comm_empty(comm_empty), .comm_deq(comm_deq),
        .comm_d(comm_d), .comm_full(comm_full), .comm_enq(comm_enq), .buf_sel(buf_sel),
        .run_start(run_start), .run_len(run_len), .run_done(run_done), .run_result(run_result),
        .busy(busy), .len_err(len_err), .block_count(block_count)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] tok;
        logic [31:0] res;
        logic [31:0] len;
        logic [31:0] bsel;
        logic [31:0] lerr;
    } vec_t;

    vec_t        tbl[5];
    int          checks = 0, failures = 0;
    int          n_deq = 0, n_enq = 0, full_viol = 0;
    logic [31:0] inq[$];
    logic [31:0] last_enq = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic refresh();
        comm_empty = (inq.size() == 0);
        comm_q     = comm_empty ? '0 : inq[0];
    endtask

    task automatic push(input logic [31:0] v);
        inq.push_back(v);
        refresh();
    endtask

    // One clock; models the channel pop/push at the edge, returns at edge+1.
    task automatic cyc();
        logic d, e, f;
        logic [31:0] dd;
        d = comm_deq; e = comm_enq; f = comm_full; dd = comm_d;
        @(posedge CLK); #1;
        if (d) begin
            n_deq++;
            if (inq.size() > 0) void'(inq.pop_front());
        end
        if (e) begin
            n_enq++;
            last_enq = dd;
            if (f) full_viol++;
        end
        refresh();
    endtask

    task automatic do_reset();
        RST = 1'b0; run_done = 1'b0; run_result = '0; comm_full = 1'b0;
        inq.delete(); refresh();
        repeat (2) @(posedge CLK);
        #1 RST = 1'b1;
    endtask

    task automatic wait_start(input string nm);
        int k = 0;
        while (!run_start && k < 20) begin cyc(); k++; end
        chk({nm, " run_start seen"}, 32'(run_start), 1);
    endtask

    task automatic wait_enq(input string nm);
        int k = 0;
        while (!comm_enq && k < 20) begin cyc(); k++; end
        chk({nm, " comm_enq seen"}, 32'(comm_enq), 1);
    endtask

    task automatic run_block(input string nm, input logic [31:0] tok, input logic [31:0] res,
                             input logic [31:0] len, input logic [31:0] bsel);
        push(tok);
        wait_start(nm);
        chk({nm, " run_len"}, 32'(run_len), len);
        chk({nm, " buf_sel"}, 32'(buf_sel), bsel);
        chk({nm, " busy"}, 32'(busy), 1);
        cyc();
        run_done = 1'b1; run_result = res;
        cyc();
        run_done = 1'b0;
        wait_enq(nm);
        chk({nm, " comm_d"}, comm_d, res);
        chk({nm, " busy after"}, 32'(busy), 0);
        cyc();
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, " comm_deq"}, 32'(comm_deq), 0);
        chk({nm, " comm_enq"}, 32'(comm_enq), 0);
        chk({nm, " comm_d"}, comm_d, 0);
        chk({nm, " run_start"}, 32'(run_start), 0);
        chk({nm, " run_len"}, 32'(run_len), 0);
        chk({nm, " buf_sel"}, 32'(buf_sel), 1);
        chk({nm, " busy"}, 32'(busy), 0);
        chk({nm, " len_err"}, 32'(len_err), 0);
        chk({nm, " block_count"}, 32'(block_count), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad, enq0;
        tbl[0] = '{tok: 32'd16384,   res: 32'h1111, len: 32'd16384, bsel: 0, lerr: 0};
        tbl[1] = '{tok: 32'd1,       res: 32'h2222, len: 32'd1,     bsel: 1, lerr: 0};
        tbl[2] = '{tok: 32'h10000,   res: 32'h3333, len: 32'd16384, bsel: 0, lerr: 1};
        tbl[3] = '{tok: 32'd7,       res: 32'h4444, len: 32'd7,     bsel: 1, lerr: 1};
        tbl[4] = '{tok: 32'd16385,   res: 32'h5555, len: 32'd16384, bsel: 0, lerr: 1};

        comm_full = 1'b0; run_done = 1'b0; run_result = '0; refresh();
        #2 do_reset();
        chk_reset_vals("rst");

        // Single block: exact latencies, run_done ignored during run_start
        push(32'd16);
        cyc();
        chk("t1 deq", 32'(comm_deq), 1);
        chk("t1 start early", 32'(run_start), 0);
        cyc();
        chk("t1 start", 32'(run_start), 1);
        chk("t1 buf_sel", 32'(buf_sel), 0);
        chk("t1 run_len", 32'(run_len), 16);
        chk("t1 busy", 32'(busy), 1);
        run_done = 1'b1; run_result = 32'h55;
        cyc();
        run_done = 1'b0;
        chk("t1 start pulse", 32'(run_start), 0);
        cyc();
        chk("t1 early done ignored cnt", 32'(block_count), 0);
        chk("t1 early done ignored enq", 32'(comm_enq), 0);
        run_done = 1'b1; run_result = 32'h78;
        cyc();
        run_done = 1'b0;
        chk("t1 cnt", 32'(block_count), 1);
        chk("t1 enq early", 32'(comm_enq), 0);
        cyc();
        chk("t1 enq", 32'(comm_enq), 1);
        chk("t1 comm_d", comm_d, 32'h78);
        chk("t1 busy end", 32'(busy), 0);
        cyc();
        chk("t1 enq pulse", 32'(comm_enq), 0);
        chk("t1 enq value", last_enq, 32'h78);

        // Back-to-back tokens: prefetch during RUN, start 2 cycles after enq
        do_reset();
        n_deq = 0;
        push(32'd8); push(32'd8);
        cyc();
        cyc();
        chk("t2 start1", 32'(run_start), 1);
        chk("t2 buf1", 32'(buf_sel), 0);
        cyc();
        chk("t2 prefetch deq", 32'(comm_deq), 1);
        run_done = 1'b1; run_result = 32'hA1;
        cyc();
        run_done = 1'b0;
        chk("t2 chan empty", 32'(comm_empty), 1);
        cyc();
        chk("t2 enq1", 32'(comm_enq), 1);
        chk("t2 d1", comm_d, 32'hA1);
        cyc();
        chk("t2 no start yet", 32'(run_start), 0);
        chk("t2 no deq idle", 32'(comm_deq), 0);
        cyc();
        chk("t2 start2", 32'(run_start), 1);
        chk("t2 buf2", 32'(buf_sel), 1);
        chk("t2 len2", 32'(run_len), 8);
        cyc();
        run_done = 1'b1; run_result = 32'hA2;
        cyc();
        run_done = 1'b0;
        wait_enq("t2 blk2");
        chk("t2 d2", comm_d, 32'hA2);
        cyc();
        chk("t2 deq count", n_deq, 2);

        // Channel full while reporting
        do_reset();
        push(32'd5);
        wait_start("t3");
        cyc();
        comm_full = 1'b1;
        run_done = 1'b1; run_result = 32'hBEEF;
        cyc();
        run_done = 1'b0;
        bad = 0;
        repeat (10) begin
            cyc();
            if (comm_enq || !busy) bad++;
        end
        chk("t3 hold while full", bad, 0);
        enq0 = n_enq;
        comm_full = 1'b0;
        cyc();
        chk("t3 enq", 32'(comm_enq), 1);
        chk("t3 d", comm_d, 32'hBEEF);
        cyc();
        chk("t3 single enq", n_enq - enq0, 1);
        chk("t3 full violation", full_viol, 0);

        // Length table: exact max, minimum, clipping, sticky len_err
        do_reset();
        for (int i = 0; i < 5; i++) begin
            run_block($sformatf("vec%0d", i), tbl[i].tok, tbl[i].res, tbl[i].len, tbl[i].bsel);
            chk($sformatf("vec%0d len_err", i), 32'(len_err), tbl[i].lerr);
            chk($sformatf("vec%0d count", i), 32'(block_count), i + 1);
        end

        // Reset mid-RUN with a prefetched token
        push(32'd9); push(32'd4);
        wait_start("t6");
        chk("t6 buf", 32'(buf_sel), 1);
        cyc();
        chk("t6 prefetch deq", 32'(comm_deq), 1);
        cyc();
        chk("t6 chan empty", 32'(comm_empty), 1);
        #2 RST = 1'b0;
        #1 chk_reset_vals("t6 async");
        @(posedge CLK); #1 RST = 1'b1;
        enq0 = n_enq;
        run_block("t6 new", 32'd6, 32'h66, 32'd6, 32'd0);
        chk("t6 enq count", n_enq - enq0, 1);
        chk("t6 count", 32'(block_count), 1);

        // FINISH after three blocks
        do_reset();
        run_block("t5 b0", 32'd3, 32'hC0, 32'd3, 32'd0);
        run_block("t5 b1", 32'd4, 32'hC1, 32'd4, 32'd1);
        run_block("t5 b2", 32'd5, 32'hC2, 32'd5, 32'd0);
        push(32'd0);
        wait_enq("t5 fin");
        chk("t5 comm_d", comm_d, 32'd3);
        chk("t5 count cleared", 32'(block_count), 0);
        chk("t5 buf held", 32'(buf_sel), 0);
        chk("t5 busy", 32'(busy), 0);
        cyc();
        chk("t5 no start", 32'(run_start), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
